tile_scheduler: RTL

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/cnn_pkg.sv | 11 +
 rtl/tile_loop_cnt.sv | 66 ++++++
 rtl/tile_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared scheduler types and default sizing for the conv tile pipeline.
package cnn_pkg;
   localparam int CNT_W_DEF   = 8;
   localparam int MAX_OUT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_t;
endpackage

// File: rtl/tile_loop_cnt.sv
// Two-level tile walker: ifmap index inner, weight index outer.
// Flags are registered from the next-index values so they track the indices exactly.
module tile_loop_cnt
   import cnn_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [CNT_W-1:0] num_wt,
   input  logic [CNT_W-1:0] num_if,
   output logic [CNT_W-1:0] wt_idx,
   output logic [CNT_W-1:0] if_idx,
   output logic             load_w,
   output logic             first,
   output logic             last
);
   logic [CNT_W-1:0] num_wt_q, num_if_q;
   logic [CNT_W-1:0] lim_wt, lim_if;
   logic [CNT_W-1:0] nxt_wt, nxt_if;

   // On load the limits come straight from the incoming counts.
   always_comb begin
      lim_wt = num_wt_q - CNT_W'(1);
      lim_if = num_if_q - CNT_W'(1);
      nxt_wt = wt_idx;
      nxt_if = if_idx;
      if (load) begin
         lim_wt = num_wt - CNT_W'(1);
         lim_if = num_if - CNT_W'(1);
         nxt_wt = '0;
         nxt_if = '0;
      end else if (step) begin
         if (if_idx == lim_if) begin
            nxt_if = '0;
            nxt_wt = wt_idx + CNT_W'(1);
         end else begin
            nxt_if = if_idx + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_wt_q <= '0;
         num_if_q <= '0;
         wt_idx   <= '0;
         if_idx   <= '0;
         load_w   <= 1'b0;
         first    <= 1'b0;
         last     <= 1'b0;
      end else begin
         if (load) begin
            num_wt_q <= num_wt;
            num_if_q <= num_if;
         end
         wt_idx <= nxt_wt;
         if_idx <= nxt_if;
         load_w <= (nxt_if == '0);
         first  <= (nxt_wt == '0) && (nxt_if == '0);
         last   <= (nxt_wt == lim_wt) && (nxt_if == lim_if);
      end
   end
endmodule

// File: rtl/tile_scheduler.sv
// Layer tile scheduler: walks weight/ifmap tiles and issues jobs to the conv
// controller, keeping at most MAX_OUT jobs in flight.
module tile_scheduler
   import cnn_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int MAX_OUT = MAX_OUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_num_wt,
   input  logic [CNT_W-1:0] cfg_num_if,
   output logic             job_valid,
   input  logic             job_ready,
   output logic [CNT_W-1:0] job_wt_idx,
   output logic [CNT_W-1:0] job_if_idx,
   output logic             job_load_w,
   output logic             job_first,
   output logic             job_last,
   input  logic             job_done,
   output logic             busy,
   output logic             layer_done,
   output logic             err,
   output logic [1:0]       state_dbg
);
   localparam int OUT_W = $clog2(MAX_OUT + 1);

   // Handshake: a job transfers on any cycle with job_valid && job_ready; job
   // outputs are registers and only change after a transfer.
   sched_state_t     state;
   logic [OUT_W-1:0] outstanding, out_nxt;
   logic             xfer, done_err, cfg_take, cfg_empty;

   assign xfer      = job_valid & job_ready;
   assign cfg_take  = (state == ST_IDLE) & cfg_valid;
   assign cfg_empty = (cfg_num_wt == '0) | (cfg_num_if == '0);
   assign done_err  = job_done & ~xfer & (outstanding == '0);
   assign state_dbg = state;

   always_comb begin
      out_nxt = outstanding;
      if (xfer && !job_done)
         out_nxt = outstanding + OUT_W'(1);
      else if (!xfer && job_done && outstanding != '0)
         out_nxt = outstanding - OUT_W'(1);
   end

   tile_loop_cnt #(.CNT_W(CNT_W)) u_loop (
      .clk    (clk),
      .rst    (rst),
      .load   (cfg_take & ~cfg_empty),
      .step   (xfer),
      .num_wt (cfg_num_wt),
      .num_if (cfg_num_if),
      .wt_idx (job_wt_idx),
      .if_idx (job_if_idx),
      .load_w (job_load_w),
      .first  (job_first),
      .last   (job_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         outstanding <= '0;
         job_valid   <= 1'b0;
         layer_done  <= 1'b0;
         err         <= 1'b0;
         busy        <= 1'b0;
         cfg_ready   <= 1'b1;
      end else begin
         layer_done  <= 1'b0;
         outstanding <= out_nxt;
         if (done_err)
            err <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cfg_take) begin
                  if (cfg_empty) begin
                     layer_done <= 1'b1;
                  end else begin
                     state     <= ST_ISSUE;
                     job_valid <= (out_nxt < OUT_W'(MAX_OUT));
                     busy      <= 1'b1;
                     cfg_ready <= 1'b0;
                  end
               end
            end
            ST_ISSUE: begin
               if (xfer && job_last) begin
                  state     <= ST_DRAIN;
                  job_valid <= 1'b0;
               end else begin
                  job_valid <= (out_nxt < OUT_W'(MAX_OUT));
               end
            end
            ST_DRAIN: begin
               if (out_nxt == '0) begin
                  state      <= ST_IDLE;
                  layer_done <= 1'b1;
                  busy       <= 1'b0;
                  cfg_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               job_valid <= 1'b0;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
